// File: rtl/ddma_rx_pkg.sv
// Shared types and helpers for the ddma_rx receive DMA block.
// Build option DDMA_RX_SIZE_CHECK_EN is consumed by ddma_rx.sv.
package ddma_rx_pkg;

  typedef enum logic [2:0] {
    S_DISARMED,
    S_WAIT_HDR,
    S_WAIT_SIZE,
    S_PAYLOAD,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int HDR_FLIT_IDX  = 0;
  localparam int SIZE_FLIT_IDX = 1;

  // Number of flit lanes in one memory word.
  function automatic int pack_ratio(input int mem_w, input int flit_w);
    return mem_w / flit_w;
  endfunction

endpackage

// File: rtl/ddma_rx_packer.sv
// Packs payload flits little-endian into a memory word; flush clears all lanes
// so a partially filled word carries zeros in its unused upper lanes.
module ddma_rx_packer
  import ddma_rx_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load,
  input  logic                        i_flush,
  input  logic [FLIT_WIDTH-1:0]       i_flit,
  output logic [MEMORY_BUS_WIDTH-1:0] o_word,
  output logic                        o_last_lane
);

  localparam int K      = pack_ratio(MEMORY_BUS_WIDTH, FLIT_WIDTH);
  localparam int FILL_W = (K > 1) ? $clog2(K) : 1;

  logic [MEMORY_BUS_WIDTH-1:0] r_word;
  logic [FILL_W-1:0]           r_fill;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_fill <= '0;
    end else if (i_flush) begin
      r_word <= '0;
      r_fill <= '0;
    end else if (i_load) begin
      for (int i = 0; i < K; i++) begin
        if (r_fill == FILL_W'(i)) r_word[i*FLIT_WIDTH +: FLIT_WIDTH] <= i_flit;
      end
      r_fill <= r_fill + 1'b1;
    end
  end

  assign o_word      = r_word;
  assign o_last_lane = (r_fill == FILL_W'(K - 1));

endmodule

// File: rtl/ddma_rx.sv
// Receive DMA: accepts router packets (header, size, payload) and writes the
// payload into memory at an armed base. `DDMA_RX_SIZE_CHECK_EN adds cfg_max drop.
module ddma_rx
  import ddma_rx_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FLIT_WIDTH-1:0]       i_rx_flit,
  input  logic                        i_rx_valid,
  output logic                        o_rx_ready,
  output logic                        o_mem_req,
  output logic [MEMORY_BUS_WIDTH-1:0] o_mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] o_mem_wdata,
  input  logic                        i_mem_gnt,
  input  logic [MEMORY_BUS_WIDTH-1:0] i_cfg_base,
  input  logic                        i_cfg_arm,
  input  logic                        i_cpu_ack,
`ifdef DDMA_RX_SIZE_CHECK_EN
  input  logic [FLIT_WIDTH-1:0]       i_cfg_max,
`endif
  output logic                        o_pkt_ready,
  output logic [FLIT_WIDTH-1:0]       o_pkt_size,
  output logic                        o_pkt_err
);

  state_e                      r_state, w_next;
  logic [MEMORY_BUS_WIDTH-1:0] r_ptr;
  logic [FLIT_WIDTH-1:0]       r_remain;
  logic [FLIT_WIDTH-1:0]       r_size;
  logic                        w_take, w_arm, w_load, w_flush, w_last_lane, w_drop;
  logic                        w_last_flit;
  logic [MEMORY_BUS_WIDTH-1:0] w_word;

  assign w_take      = i_rx_valid & o_rx_ready;
  assign w_arm       = i_cfg_arm & ((r_state == S_DISARMED) | ((r_state == S_DONE) & i_cpu_ack));
  assign w_last_flit = (r_remain == FLIT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_DISARMED;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    o_rx_ready = 1'b0;
    w_load     = 1'b0;
    w_flush    = 1'b0;
    case (r_state)
      S_DISARMED: if (i_cfg_arm) w_next = S_WAIT_HDR;
      S_WAIT_HDR: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) w_next = S_WAIT_SIZE;
      end
      S_WAIT_SIZE: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) w_next = (i_rx_flit == '0) ? S_DONE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          if (w_drop) begin
            if (w_last_flit) w_next = S_DONE;
          end else begin
            w_load = 1'b1;
            if (w_last_lane || w_last_flit) w_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (i_mem_gnt) begin
          w_flush = 1'b1;
          w_next  = (r_remain == '0) ? S_DONE : S_PAYLOAD;
        end
      end
      S_DONE: if (i_cpu_ack) w_next = i_cfg_arm ? S_WAIT_HDR : S_DISARMED;
      default: w_next = S_DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_remain <= '0;
      r_size   <= '0;
    end else begin
      if (w_arm) r_ptr <= i_cfg_base;
      if ((r_state == S_WAIT_SIZE) && w_take) begin
        r_size   <= i_rx_flit;
        r_remain <= i_rx_flit;
      end
      if ((r_state == S_PAYLOAD) && w_take) r_remain <= r_remain - 1'b1;
      if ((r_state == S_WRITE) && i_mem_gnt) r_ptr <= r_ptr + 1'b1;
    end
  end

`ifdef DDMA_RX_SIZE_CHECK_EN
  logic [FLIT_WIDTH-1:0] r_max;
  logic                  r_drop;

  // The drop decision is made once, on the size flit, against the armed limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_arm) r_max <= i_cfg_max;
      if ((r_state == S_WAIT_SIZE) && w_take) r_drop <= (i_rx_flit > r_max);
    end
  end
  assign w_drop = r_drop;
`else
  assign w_drop = 1'b0;
`endif

  ddma_rx_packer #(
    .MEMORY_BUS_WIDTH(MEMORY_BUS_WIDTH),
    .FLIT_WIDTH      (FLIT_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_flit     (i_rx_flit),
    .o_word     (w_word),
    .o_last_lane(w_last_lane)
  );

  assign o_mem_req   = (r_state == S_WRITE);
  assign o_mem_addr  = r_ptr;
  assign o_mem_wdata = w_word;
  assign o_pkt_ready = (r_state == S_DONE);
  assign o_pkt_size  = r_size;
  assign o_pkt_err   = (r_state == S_DONE) & w_drop;

endmodule

// File: tb/tb_ddma_rx.sv
// Randomized self-checking bench for ddma_rx against a packet-level memory model.
// Build with DDMA_RX_SIZE_CHECK_EN to also exercise the drop path.
module tb_ddma_rx;

  localparam int MW = 32;
  localparam int FW = 16;
  localparam int K  = MW / FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] rx_flit;
  logic          rx_valid;
  logic          o_rx_ready, o_mem_req, o_pkt_ready, o_pkt_err;
  logic [MW-1:0] o_mem_addr, o_mem_wdata;
  logic          mem_gnt;
  logic [MW-1:0] cfg_base;
  logic          cfg_arm, cpu_ack;
  logic [FW-1:0] cfg_max = 16'hFFFF;
  logic [FW-1:0] o_pkt_size;

  always #5 clk = ~clk;

  ddma_rx #(.MEMORY_BUS_WIDTH(MW), .FLIT_WIDTH(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_flit  (rx_flit),
    .i_rx_valid (rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt  (mem_gnt),
    .i_cfg_base (cfg_base),
    .i_cfg_arm  (cfg_arm),
    .i_cpu_ack  (cpu_ack),
`ifdef DDMA_RX_SIZE_CHECK_EN
    .i_cfg_max  (cfg_max),
`endif
    .o_pkt_ready(o_pkt_ready),
    .o_pkt_size (o_pkt_size),
    .o_pkt_err  (o_pkt_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Memory responder: grants, records completed writes, checks stalled requests hold.
  bit            always_gnt = 1'b1;
  bit            hold_low   = 1'b0;
  bit            stall_en   = 1'b0;
  int            stall_left = 0;
  int            last_grant_cyc = 0;
  logic [MW-1:0] wq_addr[$];
  logic [MW-1:0] wq_data[$];

  initial begin
    logic          prev_req, prev_gnt;
    logic [MW-1:0] prev_addr, prev_data;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0; prev_data = '0;
    mem_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_gnt = 1'b0; prev_req = 1'b0; stall_left = 0;
      end else begin
        if (o_mem_req && !prev_req && stall_en) begin
          stall_left = 5;
          stall_en   = 1'b0;
        end
        if (stall_left > 0) begin
          mem_gnt = 1'b0;
          stall_left--;
          check("stall_rx_ready", o_rx_ready, 0);
        end else if (hold_low) mem_gnt = 1'b0;
        else mem_gnt = always_gnt ? 1'b1 : 1'($urandom_range(0, 1));
        if (o_mem_req && prev_req && !prev_gnt) begin
          check("stall_addr_stable", o_mem_addr, prev_addr);
          check("stall_data_stable", o_mem_wdata, prev_data);
        end
        if (o_mem_req && mem_gnt) begin
          wq_addr.push_back(o_mem_addr);
          wq_data.push_back(o_mem_wdata);
          last_grant_cyc = cyc_cnt;
        end
        prev_req = o_mem_req; prev_gnt = mem_gnt;
        prev_addr = o_mem_addr; prev_data = o_mem_data_hold(o_mem_wdata);
      end
    end
  end

  function automatic logic [MW-1:0] o_mem_data_hold(input logic [MW-1:0] d);
    return d;
  endfunction

  logic [FW-1:0] pkt_fl[$];

  task automatic fill_rand(input int n);
    pkt_fl.delete();
    for (int i = 0; i < n; i++) pkt_fl.push_back(FW'($urandom));
  endtask

  task automatic send(input logic [FW-1:0] f, input bit gaps, output int cyc);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_valid = 1'b1;
    rx_flit  = f;
    while (!o_rx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", o_rx_ready, 1);
    cyc = cyc_cnt;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_flit  = FW'($urandom);
  endtask

  task automatic wait_ready(output int cyc);
    int t = 0;
    while (!o_pkt_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("pkt_ready_timeout", o_pkt_ready, 1);
    cyc = cyc_cnt;
  endtask

  task automatic arm(input logic [MW-1:0] b);
    cfg_arm = 1'b1; cfg_base = b;
    @(negedge clk);
    cfg_arm = 1'b0; cfg_base = $urandom;
  endtask

  task automatic ack(input bit with_arm, input logic [MW-1:0] b);
    cpu_ack = 1'b1; cfg_arm = with_arm; cfg_base = b;
    @(negedge clk);
    cpu_ack = 1'b0; cfg_arm = 1'b0;
    check("ack_pkt_ready", o_pkt_ready, 0);
    check("ack_rx_ready", o_rx_ready, with_arm);
  endtask

  // Reference: word w holds payload flits w*K .. w*K+K-1, lane j at bits j*FW, missing lanes zero.
  task automatic expect_writes(input string tag, input logic [MW-1:0] base, input int n);
    int nw = (n + K - 1) / K;
    check({tag, "_wr_count"}, wq_addr.size(), nw);
    for (int w = 0; w < nw && w < wq_addr.size(); w++) begin
      logic [MW-1:0] exp_d = '0;
      for (int j = 0; j < K; j++)
        if (w * K + j < n) exp_d = exp_d | (MW'(pkt_fl[w * K + j]) << (j * FW));
      check({tag, "_wr_addr"}, wq_addr[w], base + MW'(w));
      check({tag, "_wr_data"}, wq_data[w], exp_d);
    end
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic run_pkt(input logic [MW-1:0] base, input bit gaps, input string tag);
    int n = pkt_fl.size();
    int c_last, c_rdy, exp_rdy;
    bit drop = 1'b0;
`ifdef DDMA_RX_SIZE_CHECK_EN
    drop = (n > int'(cfg_max));
`endif
    send(FW'($urandom), gaps, c_last);
    send(FW'(n), gaps, c_last);
    foreach (pkt_fl[i]) send(pkt_fl[i], gaps, c_last);
    wait_ready(c_rdy);
    exp_rdy = (n == 0 || drop) ? c_last + 1 : last_grant_cyc + 1;
    check({tag, "_rdy_cycle"}, c_rdy, exp_rdy);
    check({tag, "_pkt_size"}, o_pkt_size, n);
    check({tag, "_pkt_err"}, o_pkt_err, drop);
    expect_writes(tag, base, drop ? 0 : n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_ready"}, o_rx_ready, 0);
    check({tag, "_mem_req"}, o_mem_req, 0);
    check({tag, "_mem_addr"}, o_mem_addr, 0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 0);
    check({tag, "_pkt_ready"}, o_pkt_ready, 0);
    check({tag, "_pkt_size"}, o_pkt_size, 0);
    check({tag, "_pkt_err"}, o_pkt_err, 0);
  endtask

  initial begin
    int c;
    logic [MW-1:0] b;
    rx_valid = 1'b0; rx_flit = '0; cfg_base = '0; cfg_arm = 1'b0; cpu_ack = 1'b0;
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Flits offered before arming are refused.
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("disarmed_rx_ready", o_rx_ready, 0);
    end
    rx_valid = 1'b0;
    check("disarmed_no_write", wq_addr.size(), 0);

    arm(32'h100);
    pkt_fl = '{16'h1, 16'h2, 16'h3, 16'h4};
    run_pkt(32'h100, 1'b0, "n4");

    // Second packet while DONE is refused.
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_rx_ready", o_rx_ready, 0);
      check("done_pkt_ready", o_pkt_ready, 1);
    end
    rx_valid = 1'b0;
    ack(1'b0, '0);

    arm(32'h100);
    pkt_fl = '{16'h1, 16'h2, 16'h3};
    stall_en = 1'b1;
    run_pkt(32'h100, 1'b0, "n3_stall");

    ack(1'b1, 32'h300);
    pkt_fl.delete();
    run_pkt(32'h300, 1'b0, "n0");

    ack(1'b1, 32'h400);
    fill_rand(5);
    run_pkt(32'h400, 1'b1, "rebase");

    always_gnt = 1'b0;
    for (int p = 0; p < 25; p++) begin
      b = ($urandom_range(0, 1) == 1) ? MW'($urandom) : 32'hFFFF_FFFF - MW'($urandom_range(0, 3));
`ifdef DDMA_RX_SIZE_CHECK_EN
      cfg_max = FW'($urandom_range(0, 9));
`endif
      if ($urandom_range(0, 1) == 1) ack(1'b1, b);
      else begin
        ack(1'b0, '0);
        arm(b);
      end
      fill_rand($urandom_range(0, 9));
      run_pkt(b, 1'b1, "rand");
    end
    always_gnt = 1'b1;

`ifdef DDMA_RX_SIZE_CHECK_EN
    cfg_max = 16'd2;
    ack(1'b1, 32'h600);
    fill_rand(4);
    run_pkt(32'h600, 1'b0, "drop");
    ack(1'b1, 32'h610);
    check("drop_err_cleared", o_pkt_err, 0);
    fill_rand(2);
    run_pkt(32'h610, 1'b0, "at_max");
`endif

    // Reset in the middle of a packet.
    ack(1'b1, 32'h700);
    hold_low = 1'b1;
    fill_rand(4);
    send(FW'($urandom), 1'b0, c);
    send(16'd4, 1'b0, c);
    send(pkt_fl[0], 1'b0, c);
    send(pkt_fl[1], 1'b0, c);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    wq_addr.delete();
    wq_data.delete();
    hold_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_rx_ready", o_rx_ready, 0);
      check("post_reset_mem_req", o_mem_req, 0);
    end
    rx_valid = 1'b0;
    check("post_reset_no_write", wq_addr.size(), 0);
    cfg_max = 16'hFFFF;
    arm(32'h500);
    fill_rand(4);
    run_pkt(32'h500, 1'b1, "rearm");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=0x0 expected=0x1");
    $fatal(1, "timeout");
  end

endmodule
